// File: rtl/obi_mmio_ctrl_multi.sv
// OBI MMIO control/status block for up to 16 accelerator channels: start pulse, busy,
// sticky W1C done/match, saturating run-cycle counter and a maskable level interrupt.
package obi_mmio_ctrl_multi_pkg;
  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } obi_rsp_t;
endpackage

// state | meaning
// IDLE  | channel waiting for a CTRL start
// RUN   | channel started, counting cycles until done_i
module obi_mmio_ctrl_multi #(
  parameter int unsigned NumChannels = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned CntWidth    = 32,
  parameter type obi_req_t = obi_mmio_ctrl_multi_pkg::obi_req_t,
  parameter type obi_rsp_t = obi_mmio_ctrl_multi_pkg::obi_rsp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  obi_req_t               obi_req_i,
  output obi_rsp_t               obi_rsp_o,
  output logic [NumChannels-1:0] start_o,
  input  logic [NumChannels-1:0] done_i,
  input  logic [NumChannels-1:0] match_i,
  output logic                   irq_o
);

  typedef enum logic {IDLE, RUN} state_e;

  localparam int unsigned CycBase = 5;

  state_e                 state_q [NumChannels];
  state_e                 state_d [NumChannels];
  logic [CntWidth-1:0]    cnt_q [NumChannels];
  logic [CntWidth-1:0]    cnt_d [NumChannels];
  logic [CntWidth-1:0]    cycles_q [NumChannels];
  logic [CntWidth-1:0]    cycles_d [NumChannels];
  logic [NumChannels-1:0] done_q, done_d, match_q, match_d;
  logic [NumChannels-1:0] irq_en_q, irq_en_d, start_q, start_d;
  logic                   irq_q, irq_d, rvalid_q, rvalid_d, err_q, err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [$bits(obi_req_i.aid)-1:0] rid_q, rid_d;

  logic [5:0]             word_idx;
  logic [NumChannels-1:0] wr_bits, busy, start_req, clr_req, set_req;
  logic [CntWidth-1:0]    cnt_inc;
  logic [DataWidth-1:0]   cyc_rdata;
  logic                   cyc_hit;
  logic                   unused_req;

  assign word_idx   = obi_req_i.addr[7:2];
  assign wr_bits    = obi_req_i.wdata[NumChannels-1:0];
  assign unused_req = ^{obi_req_i.be, obi_req_i.addr, obi_req_i.wdata};

  always_comb begin
    busy      = '0;
    cyc_hit   = 1'b0;
    cyc_rdata = '0;
    for (int c = 0; c < NumChannels; c++) begin
      busy[c] = (state_q[c] == RUN);
      if (int'(word_idx) == int'(CycBase) + c) begin
        cyc_hit   = 1'b1;
        cyc_rdata = DataWidth'(cycles_q[c]);
      end
    end
  end

  // Bus decode: rdata is built from pre-edge state, writes take effect at the edge.
  always_comb begin
    rvalid_d  = obi_req_i.req;
    rid_d     = obi_req_i.req ? obi_req_i.aid : '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    start_req = '0;
    clr_req   = '0;
    irq_en_d  = irq_en_q;
    if (obi_req_i.req) begin
      if (obi_req_i.addr[1:0] != 2'b00) begin
        err_d = 1'b1;
      end else if (word_idx == 6'd0) begin
        if (obi_req_i.we) begin
          if ((wr_bits & busy) != '0) err_d = 1'b1;
          else start_req = wr_bits;
        end
      end else if (word_idx == 6'd1) begin
        if (obi_req_i.we) err_d = 1'b1;
        else rdata_d = DataWidth'(busy);
      end else if (word_idx == 6'd2) begin
        if (obi_req_i.we) clr_req = wr_bits;
        else rdata_d = DataWidth'(done_q);
      end else if (word_idx == 6'd3) begin
        if (obi_req_i.we) clr_req = wr_bits;
        else rdata_d = DataWidth'(match_q);
      end else if (word_idx == 6'd4) begin
        if (obi_req_i.we) irq_en_d = wr_bits;
        else rdata_d = DataWidth'(irq_en_q);
      end else if (cyc_hit) begin
        if (obi_req_i.we) err_d = 1'b1;
        else rdata_d = cyc_rdata;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cycles_d = cycles_q;
    start_d  = '0;
    set_req  = '0;
    cnt_inc  = '0;
    match_d  = match_q;
    for (int c = 0; c < NumChannels; c++) begin
      cnt_inc = (cnt_q[c] == '1) ? cnt_q[c] : cnt_q[c] + 1'b1;
      case (state_q[c])
        IDLE: begin
          if (start_req[c]) begin
            state_d[c] = RUN;
            cnt_d[c]   = '0;
            start_d[c] = 1'b1;
          end
        end
        RUN: begin
          // The completing cycle itself is counted, so a done in the start cycle yields 1.
          if (done_i[c]) begin
            state_d[c]  = IDLE;
            cycles_d[c] = cnt_inc;
            set_req[c]  = 1'b1;
          end else begin
            cnt_d[c] = cnt_inc;
          end
        end
        default: state_d[c] = IDLE;
      endcase
      if (set_req[c]) match_d[c] = match_i[c];
      else if (clr_req[c]) match_d[c] = 1'b0;
    end
    done_d = (done_q & ~clr_req) | set_req;
    irq_d  = |(done_q & irq_en_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= '{default: IDLE};
      cnt_q    <= '{default: '0};
      cycles_q <= '{default: '0};
      done_q   <= '0;
      match_q  <= '0;
      irq_en_q <= '0;
      start_q  <= '0;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      rid_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cycles_q <= cycles_d;
      done_q   <= done_d;
      match_q  <= match_d;
      irq_en_q <= irq_en_d;
      start_q  <= start_d;
      irq_q    <= irq_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rid_q    <= rid_d;
    end
  end

  assign start_o = start_q;
  assign irq_o   = irq_q;

  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = 1'b1;
    obi_rsp_o.rvalid = rvalid_q;
    obi_rsp_o.rdata  = rdata_q;
    obi_rsp_o.err    = err_q;
    obi_rsp_o.rid    = rid_q;
  end

endmodule

// File: tb/tb_obi_mmio_ctrl_multi.sv
// Self-checking bench for obi_mmio_ctrl_multi: directed scenarios plus a random phase,
// checked every cycle against a run-length based reference model.
module tb_obi_mmio_ctrl_multi;
  import obi_mmio_ctrl_multi_pkg::*;

  localparam int NCh    = 4;
  localparam int CntW   = 4;
  localparam int CntMax = (1 << CntW) - 1;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  obi_req_t req;
  obi_rsp_t rsp;
  logic [NCh-1:0] start_o, done_i, match_i;
  logic     irq_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [NCh-1:0] m_busy, m_done, m_match, m_en;
  int m_run [NCh];
  int m_cycles [NCh];

  obi_mmio_ctrl_multi #(.NumChannels(NCh), .DataWidth(32), .CntWidth(CntW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .obi_req_i(req),
    .obi_rsp_o(rsp),
    .start_o  (start_o),
    .done_i   (done_i),
    .match_i  (match_i),
    .irq_o    (irq_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = '0; m_done = '0; m_match = '0; m_en = '0;
    for (int c = 0; c < NCh; c++) begin
      m_run[c] = 0;
      m_cycles[c] = 0;
    end
  endtask

  // One clock: predict the response to the inputs currently driven, advance the model, check.
  task automatic step();
    logic [NCh-1:0] wb, start_req, clr, set_v, new_en;
    logic [31:0] exp_rdata;
    logic exp_err, exp_rvalid, exp_irq;
    logic [3:0] exp_rid;
    int w;
    exp_rvalid = req.req;
    exp_err    = 1'b0;
    exp_rdata  = '0;
    exp_rid    = req.req ? req.aid : 4'h0;
    start_req  = '0; clr = '0; set_v = '0;
    new_en     = m_en;
    wb         = req.wdata[NCh-1:0];
    w          = int'(req.addr[7:2]);
    if (req.req) begin
      if (req.addr[1:0] != 2'b00) exp_err = 1'b1;
      else if (w == 0) begin
        if (req.we) begin
          if ((wb & m_busy) != '0) exp_err = 1'b1;
          else start_req = wb;
        end
      end
      else if (w == 1) begin if (req.we) exp_err = 1'b1; else exp_rdata = 32'(m_busy); end
      else if (w == 2) begin if (req.we) clr = wb; else exp_rdata = 32'(m_done); end
      else if (w == 3) begin if (req.we) clr = wb; else exp_rdata = 32'(m_match); end
      else if (w == 4) begin if (req.we) new_en = wb; else exp_rdata = 32'(m_en); end
      else if (w >= 5 && w < 5 + NCh) begin
        if (req.we) exp_err = 1'b1; else exp_rdata = 32'(m_cycles[w-5]);
      end
      else exp_err = 1'b1;
    end
    exp_irq = |(m_done & m_en);
    for (int c = 0; c < NCh; c++) begin
      if (m_busy[c]) begin
        m_run[c]++;
        if (done_i[c]) begin
          m_busy[c]   = 1'b0;
          m_cycles[c] = (m_run[c] > CntMax) ? CntMax : m_run[c];
          set_v[c]    = 1'b1;
        end
      end
      if (set_v[c]) begin m_done[c] = 1'b1; m_match[c] = match_i[c]; end
      else if (clr[c]) begin m_done[c] = 1'b0; m_match[c] = 1'b0; end
      if (start_req[c]) begin m_busy[c] = 1'b1; m_run[c] = 0; end
    end
    m_en = new_en;
    @(posedge clk); #1;
    chk("rvalid", rsp.rvalid, exp_rvalid);
    chk("gnt", rsp.gnt, 1'b1);
    if (exp_rvalid) begin
      chk("err", rsp.err, exp_err);
      chk("rdata", rsp.rdata, exp_rdata);
      chk("rid", rsp.rid, exp_rid);
    end
    chk("start_o", start_o, start_req);
    chk("irq_o", irq_o, exp_irq);
  endtask

  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] data);
    req.req = 1'b1; req.we = we; req.addr = addr; req.wdata = data;
    req.be = 4'hF; req.aid = 4'($urandom);
    step();
    req.req = 1'b0; req.we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Let channel c run until its k-th RUN cycle and complete there with match value m.
  task automatic complete(input int c, input int k, input logic m);
    for (int i = 0; i < 200 && m_busy[c] && m_run[c] < k - 1; i++) step();
    done_i[c] = 1'b1; match_i[c] = m;
    step();
    done_i = '0; match_i = '0;
  endtask

  initial begin
    req = '0; done_i = '0; match_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rvalid", rsp.rvalid, 1'b0);
    chk("rst_err", rsp.err, 1'b0);
    chk("rst_rdata", rsp.rdata, 32'h0);
    chk("rst_rid", rsp.rid, 4'h0);
    chk("rst_start", start_o, 4'h0);
    chk("rst_irq", irq_o, 1'b0);
    rst = 1'b0;

    // Reset state and map
    bus(0, 32'h04, 0); bus(0, 32'h08, 0); bus(0, 32'h0C, 0);
    bus(0, 32'h10, 0); bus(0, 32'h14, 0); bus(0, 32'h00, 0);
    bus(0, 32'h01, 0); bus(0, 32'h80, 0); bus(1, 32'h04, 32'hF);
    bus(0, 32'h24, 0); bus(1, 32'h18, 32'h1);

    // Single run on channel 0, completing in its 10th cycle
    bus(1, 32'h00, 32'h1);
    bus(0, 32'h04, 0);
    chk("busy_after_start", rsp.rdata, 32'h1);
    complete(0, 10, 1'b1);
    bus(0, 32'h08, 0); bus(0, 32'h0C, 0); bus(0, 32'h04, 0);
    bus(0, 32'h14, 0);
    chk("cycles0_lit", rsp.rdata, 32'd10);

    // Done in the start cycle counts as one
    bus(1, 32'h00, 32'h1);
    complete(0, 1, 1'b0);
    bus(0, 32'h14, 0);
    chk("cycles0_one", rsp.rdata, 32'd1);

    // Start while busy
    bus(1, 32'h00, 32'h4);
    idle(2);
    bus(1, 32'h00, 32'h6);
    chk("busy_start_err", rsp.err, 1'b1);
    bus(0, 32'h04, 0);
    chk("busy_only_ch2", rsp.rdata, 32'h4);
    complete(2, 6, 1'b1);

    // W1C collision on channel 3: set beats clear, match takes the new value
    bus(1, 32'h00, 32'h8);
    complete(3, 3, 1'b1);
    bus(1, 32'h00, 32'h8);
    idle(2);
    done_i[3] = 1'b1; match_i[3] = 1'b0;
    bus(1, 32'h08, 32'h8);
    done_i = '0; match_i = '0;
    bus(0, 32'h08, 0);
    chk("collision_done3", rsp.rdata[3], 1'b1);
    bus(0, 32'h0C, 0);
    chk("collision_match3", rsp.rdata[3], 1'b0);
    bus(1, 32'h0C, 32'hF);

    // Interrupt on channel 1
    bus(1, 32'h10, 32'h2);
    bus(1, 32'h00, 32'h2);
    complete(1, 4, 1'b1);
    idle(2);
    chk("irq_high", irq_o, 1'b1);
    bus(1, 32'h08, 32'h2);
    idle(2);
    chk("irq_low", irq_o, 1'b0);

    // Saturation
    bus(1, 32'h00, 32'h1);
    complete(0, 20, 1'b1);
    bus(0, 32'h14, 0);
    chk("cycles_sat", rsp.rdata, 32'(CntMax));

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      req.req = ($urandom_range(0, 2) != 0);
      req.we  = 1'($urandom_range(0, 1));
      req.aid = 4'($urandom);
      req.be  = 4'($urandom);
      case ($urandom_range(0, 11))
        0: req.addr = 32'h80 + 32'($urandom_range(0, 31) * 4);
        1: req.addr = 32'($urandom_range(0, 40) * 4 + $urandom_range(1, 3));
        default: req.addr = 32'($urandom_range(0, 9) * 4);
      endcase
      req.wdata = $urandom;
      done_i    = NCh'($urandom & $urandom);
      match_i   = NCh'($urandom);
      step();
    end
    req.req = 1'b0; done_i = '0; match_i = '0;
    idle(2);

    // Reset in the middle of a run, while start_o and rvalid are high
    bus(1, 32'h08, 32'hF);
    bus(1, 32'h10, 32'hF);
    idle(25);
    bus(1, 32'h00, 32'h2);
    #2 rst = 1'b1;
    #1;
    chk("midrst_start", start_o, 4'h0);
    chk("midrst_rvalid", rsp.rvalid, 1'b0);
    chk("midrst_irq", irq_o, 1'b0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(5);
    bus(0, 32'h04, 0); bus(0, 32'h08, 0); bus(0, 32'h0C, 0); bus(0, 32'h10, 0);
    for (int c = 0; c < NCh; c++) bus(0, 32'(32'h14 + 4 * c), 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
